// File: rtl/video_cap_pkg.sv
// Shared types and helpers for the video capture sink.
// Entry layout, default geometry and pixel packing.
package video_cap_pkg;

   typedef struct packed {
      logic       sof;
      logic       eol;
      logic [7:0] data;
   } cap_entry_t;

   localparam int H_ACTIVE_DEF = 256;
   localparam int V_ACTIVE_DEF = 224;

   function automatic logic [7:0] pack_pixel(
      input logic [2:0] r,
      input logic [2:0] g,
      input logic [1:0] b
   );
      return ~{b, g, r};
   endfunction

endpackage

// File: rtl/video_capture_if.sv
// Captured pixel stream towards a downstream consumer.
// Master drives data/valid, slave drives ready.
interface video_capture_if;
   logic [7:0] pix_data;
   logic       pix_sof;
   logic       pix_eol;
   logic       pix_valid;
   logic       pix_ready;

   modport master (
      output pix_data, pix_sof, pix_eol, pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data, pix_sof, pix_eol, pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/cap_fifo.sv
// First-word-fall-through FIFO with registered head outputs.
// Pointers carry a wrap bit; capacity is exactly DEPTH entries.
module cap_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [AW:0]  rptr_nxt;
   logic         rd;
   logic         wr;
   logic         nxt_valid;

   assign full = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd   = pop & valid;
   assign wr   = push & (~full | rd);

   assign rptr_nxt  = rptr + (AW+1)'(rd);
   // A fresh write is only seen one edge later.
   assign nxt_valid = (wptr != rptr_nxt);

   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         dout  <= '0;
         valid <= 1'b0;
      end else begin
         wptr  <= wptr + (AW+1)'(wr);
         rptr  <= rptr_nxt;
         valid <= nxt_valid;
         if (nxt_valid) dout <= mem[rptr_nxt[AW-1:0]];
      end
   end
endmodule

// File: rtl/video_capture.sv
// Pixel sink: samples on pixel clock rise, tags frame/line
// position and buffers entries for a valid/ready consumer.
module video_capture
   import video_cap_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pixelclk_in,
   input  logic            vblk,
   input  logic            video_valid,
   input  logic [2:0]      r_sig,
   input  logic [2:0]      g_sig,
   input  logic [1:0]      b_sig,
   video_capture_if.master pix,
   output logic            overflow,
   input  logic            ovf_clr,
   output logic            frame_done
);
   localparam int CW = $clog2(H_ACTIVE);
   localparam int RW = $clog2(V_ACTIVE);

   logic          pclk_q;
   logic          vblk_q;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          pclk_rise;
   logic          vblk_rise;
   logic          sample;
   logic          col_last;
   logic          row_last;
   logic          full;
   logic          pop;
   logic          drop;
   cap_entry_t    entry;
   cap_entry_t    head;

   assign pclk_rise = pixelclk_in & ~pclk_q;
   assign vblk_rise = vblk & ~vblk_q;
   assign sample    = pclk_rise & video_valid;
   assign col_last  = (col == CW'(H_ACTIVE-1));
   assign row_last  = (row == RW'(V_ACTIVE-1));
   assign pop       = pix.pix_valid & pix.pix_ready;
   assign drop      = sample & full & ~pop;

   assign entry.sof  = (col == '0) && (row == '0);
   assign entry.eol  = col_last;
   assign entry.data = pack_pixel(r_sig, g_sig, b_sig);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pclk_q     <= 1'b0;
         vblk_q     <= 1'b0;
         col        <= '0;
         row        <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pclk_q     <= pixelclk_in;
         vblk_q     <= vblk;
         frame_done <= sample & col_last & row_last;
         // Counters advance even for dropped pixels.
         if (vblk_rise) begin
            col <= '0;
            row <= '0;
         end else if (sample) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   cap_fifo #(
      .W     ($bits(cap_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (sample),
      .din   (entry),
      .full  (full),
      .pop   (pop),
      .dout  (head),
      .valid (pix.pix_valid)
   );

   assign pix.pix_data = head.data;
   assign pix.pix_sof  = head.sof;
   assign pix.pix_eol  = head.eol;
endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture with a 256x4 frame.
module tb_video_capture;
   localparam int H  = 256;
   localparam int V  = 4;
   localparam int FD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pixelclk_in = 1'b0;
   logic       vblk = 1'b0;
   logic       video_valid = 1'b0;
   logic [2:0] r_sig = '0;
   logic [2:0] g_sig = '0;
   logic [1:0] b_sig = '0;
   logic       overflow;
   logic       ovf_clr = 1'b0;
   logic       frame_done;

   int checks = 0;
   int failures = 0;
   int n_pop = 0;
   int n_fd = 0;

   video_capture_if pix ();

   video_capture #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pixelclk_in (pixelclk_in),
      .vblk        (vblk),
      .video_valid (video_valid),
      .r_sig       (r_sig),
      .g_sig       (g_sig),
      .b_sig       (b_sig),
      .pix         (pix),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pix.pix_valid && pix.pix_ready) n_pop++;
      if (frame_done) n_fd++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_px(input logic [7:0] v, input logic vv);
      b_sig = v[7:6];
      g_sig = v[5:3];
      r_sig = v[2:0];
      video_valid = vv;
   endtask

   task automatic px(input logic [7:0] v, input logic vv);
      set_px(v, vv);
      pixelclk_in = 1'b1;
      step();
      step();
      pixelclk_in = 1'b0;
      step();
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pixelclk_in = 1'b0;
      vblk = 1'b0;
      video_valid = 1'b0;
      ovf_clr = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pix.pix_valid, pix.pix_data, pix.pix_sof, pix.pix_eol,
           overflow, frame_done} !== 13'h0) begin
         failures++;
         $display("FAIL reset_outs got=%b/%h/%b%b/%b/%b exp=0",
                  pix.pix_valid, pix.pix_data, pix.pix_sof,
                  pix.pix_eol, overflow, frame_done);
      end
      do_reset();
   endtask

   task automatic test_basic();
      logic [7:0] exp_d;
      do_reset();
      pix.pix_ready = 1'b1;
      exp_d = ~{2'b11, 3'b010, 3'b101};
      r_sig = 3'b101;
      g_sig = 3'b010;
      b_sig = 2'b11;
      video_valid = 1'b1;
      pixelclk_in = 1'b1;
      step();
      checks++;
      if (pix.pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_lat1 valid=%b exp=0", pix.pix_valid);
      end
      step();
      checks++;
      if ({pix.pix_valid, pix.pix_sof, pix.pix_eol, pix.pix_data}
          !== {1'b1, 1'b1, 1'b0, exp_d}) begin
         failures++;
         $display("FAIL basic_lat2 v/s/e/d=%b%b%b/%h exp=110/%h",
                  pix.pix_valid, pix.pix_sof, pix.pix_eol,
                  pix.pix_data, exp_d);
      end
      pixelclk_in = 1'b0;
      step();
      checks++;
      if (pix.pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_pop valid=%b exp=0", pix.pix_valid);
      end
      step();
   endtask

   task automatic test_frame();
      int base_pop;
      int base_fd;
      logic [7:0] v;
      do_reset();
      pix.pix_ready = 1'b1;
      base_pop = n_pop;
      base_fd = n_fd;
      for (int i = 0; i < H*V; i++) begin
         v = 8'(i*37 + 11);
         set_px(v, 1'b1);
         pixelclk_in = 1'b1;
         step();
         checks++;
         if (frame_done !== (i == H*V-1)) begin
            failures++;
            $display("FAIL frame_done i=%0d got=%b", i, frame_done);
         end
         step();
         checks++;
         if ({pix.pix_valid, pix.pix_data, pix.pix_sof, pix.pix_eol}
             !== {1'b1, ~v, i == 0, (i % H) == H-1}) begin
            failures++;
            $display("FAIL frame_ent i=%0d v/d/s/e=%b/%h/%b%b exp d=%h",
                     i, pix.pix_valid, pix.pix_data, pix.pix_sof,
                     pix.pix_eol, ~v);
         end
         pixelclk_in = 1'b0;
         step();
         step();
      end
      checks++;
      if (n_pop - base_pop !== H*V) begin
         failures++;
         $display("FAIL frame_count got=%0d exp=%0d",
                  n_pop - base_pop, H*V);
      end
      checks++;
      if (n_fd - base_fd !== 1) begin
         failures++;
         $display("FAIL frame_pulses got=%0d exp=1", n_fd - base_fd);
      end
      set_px(8'h5a, 1'b1);
      pixelclk_in = 1'b1;
      step();
      step();
      checks++;
      if ({pix.pix_valid, pix.pix_sof} !== 2'b11) begin
         failures++;
         $display("FAIL frame_next_sof v/s=%b%b exp=11",
                  pix.pix_valid, pix.pix_sof);
      end
      pixelclk_in = 1'b0;
      step();
      step();
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      do_reset();
      pix.pix_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         v = 8'(i*13 + 5);
         set_px(v, 1'b1);
         pixelclk_in = 1'b1;
         step();
         checks++;
         if (overflow !== (i >= FD)) begin
            failures++;
            $display("FAIL ovf_set i=%0d got=%b exp=%b",
                     i, overflow, i >= FD);
         end
         step();
         pixelclk_in = 1'b0;
         step();
         step();
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr got=%b exp=0", overflow);
      end
      pix.pix_ready = 1'b1;
      for (int k = 0; k < FD; k++) begin
         v = 8'(k*13 + 5);
         checks++;
         if ({pix.pix_valid, pix.pix_data, pix.pix_sof}
             !== {1'b1, ~v, k == 0}) begin
            failures++;
            $display("FAIL ovf_drain k=%0d v/d/s=%b/%h/%b exp d=%h",
                     k, pix.pix_valid, pix.pix_data, pix.pix_sof, ~v);
         end
         step();
      end
      checks++;
      if (pix.pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_empty valid=%b exp=0", pix.pix_valid);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] v;
      do_reset();
      pix.pix_ready = 1'b0;
      for (int i = 0; i < FD; i++) px(8'(i*29 + 1), 1'b1);
      v = 8'(FD*29 + 1);
      set_px(v, 1'b1);
      pix.pix_ready = 1'b1;
      pixelclk_in = 1'b1;
      step();
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL fullpop_ovf got=%b exp=0", overflow);
      end
      pixelclk_in = 1'b0;
      for (int k = 1; k <= FD; k++) begin
         v = 8'(k*29 + 1);
         checks++;
         if ({pix.pix_valid, pix.pix_data} !== {1'b1, ~v}) begin
            failures++;
            $display("FAIL fullpop_drain k=%0d v/d=%b/%h exp d=%h",
                     k, pix.pix_valid, pix.pix_data, ~v);
         end
         step();
      end
      checks++;
      if ({pix.pix_valid, overflow} !== 2'b00) begin
         failures++;
         $display("FAIL fullpop_end v/ovf=%b%b exp=00",
                  pix.pix_valid, overflow);
      end
   endtask

   task automatic test_resync();
      int base_fd;
      int base_pop;
      do_reset();
      pix.pix_ready = 1'b1;
      base_fd = n_fd;
      for (int i = 0; i < 300; i++) px(8'(i), 1'b1);
      vblk = 1'b1;
      step();
      step();
      vblk = 1'b0;
      step();
      base_pop = n_pop;
      px(8'hc3, 1'b0);
      pixelclk_in = 1'b1;
      repeat (4) step();
      pixelclk_in = 1'b0;
      step();
      checks++;
      if (n_pop - base_pop !== 0) begin
         failures++;
         $display("FAIL ignored_push got=%0d exp=0", n_pop - base_pop);
      end
      set_px(8'h3c, 1'b1);
      pixelclk_in = 1'b1;
      step();
      step();
      checks++;
      if ({pix.pix_valid, pix.pix_sof, pix.pix_data}
          !== {2'b11, 8'hc3}) begin
         failures++;
         $display("FAIL resync_sof v/s/d=%b%b/%h exp=11/c3",
                  pix.pix_valid, pix.pix_sof, pix.pix_data);
      end
      pixelclk_in = 1'b0;
      step();
      checks++;
      if (n_fd - base_fd !== 0) begin
         failures++;
         $display("FAIL resync_fd got=%0d exp=0", n_fd - base_fd);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pix.pix_ready = 1'b0;
      for (int i = 0; i < 5; i++) px(8'(i + 100), 1'b1);
      checks++;
      if (pix.pix_valid !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre valid=%b exp=1", pix.pix_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pix.pix_valid, overflow} !== 2'b00) begin
         failures++;
         $display("FAIL arst_now v/ovf=%b%b exp=00",
                  pix.pix_valid, overflow);
      end
      step();
      rst_n = 1'b1;
      pix.pix_ready = 1'b1;
      step();
      set_px(8'h81, 1'b1);
      pixelclk_in = 1'b1;
      step();
      step();
      checks++;
      if ({pix.pix_valid, pix.pix_sof, pix.pix_data}
          !== {2'b11, 8'h7e}) begin
         failures++;
         $display("FAIL arst_sof v/s/d=%b%b/%h exp=11/7e",
                  pix.pix_valid, pix.pix_sof, pix.pix_data);
      end
      pixelclk_in = 1'b0;
      step();
      checks++;
      if (pix.pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_flush valid=%b exp=0", pix.pix_valid);
      end
   endtask

   initial begin
      pix.pix_ready = 1'b0;
      test_reset();
      test_basic();
      test_frame();
      test_overflow();
      test_full_pop();
      test_resync();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
